// File: rtl/riscv_test_sequencer.sv
// Run controller for riscv-tests compliance runs: sequences Core's reset, then
// watches PC/gp to report pass, fail or timeout.
module riscv_test_sequencer #(
   parameter logic [31:0] END_PC       = 32'h44,
   parameter logic [31:0] PASS_GP      = 32'h1,
   parameter int unsigned RESET_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 5000,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      core_pc,
   input  logic [31:0]      core_gp,
   output logic             core_rst,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [31:0]      RST_LAST = 32'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StResetCore, StRun, StDone} state_t;

   state_t      state;
   logic [31:0] rst_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= StIdle;
         rst_cnt     <= '0;
         core_rst    <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               core_rst <= 1'b1;
               // abort has no effect here; only start leaves IDLE/DONE
               if (start) begin
                  state       <= StResetCore;
                  rst_cnt     <= '0;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  fail        <= 1'b0;
                  timeout     <= 1'b0;
                  cycle_count <= '0;
               end
            end
            StResetCore: begin
               if (abort) begin
                  state       <= StIdle;
                  core_rst    <= 1'b1;
                  busy        <= 1'b0;
                  cycle_count <= '0;
               end else if (rst_cnt == RST_LAST) begin
                  state    <= StRun;
                  core_rst <= 1'b0;
               end else begin
                  rst_cnt <= rst_cnt + 32'd1;
               end
            end
            StRun: begin
               if (abort) begin
                  state       <= StIdle;
                  core_rst    <= 1'b1;
                  busy        <= 1'b0;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  fail        <= 1'b0;
                  timeout     <= 1'b0;
                  cycle_count <= '0;
               end else if (core_pc == END_PC) begin
                  // PC match outranks a simultaneous timeout
                  state    <= StDone;
                  core_rst <= 1'b1;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  pass     <= (core_gp == PASS_GP);
                  fail     <= (core_gp != PASS_GP);
               end else if (cycle_count == CNT_LAST) begin
                  state    <= StDone;
                  core_rst <= 1'b1;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  fail     <= 1'b1;
                  timeout  <= 1'b1;
               end else begin
                  cycle_count <= cycle_count + 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_test_sequencer.sv
// Directed bench for riscv_test_sequencer: pass, fail, timeout, tie, async
// reset, abort and rerun, on a default instance and a TIMEOUT=50 instance.
module tb_riscv_test_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] core_pc = 32'h0;
   logic [31:0] core_gp = 32'h0;

   logic        core_rst, busy, done, pass, fail, timeout;
   logic [31:0] cycle_count;
   logic        t_core_rst, t_busy, t_done, t_pass, t_fail, t_timeout;
   logic [31:0] t_cycle_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   riscv_test_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .core_pc(core_pc), .core_gp(core_gp),
      .core_rst(core_rst), .busy(busy), .done(done), .pass(pass),
      .fail(fail), .timeout(timeout), .cycle_count(cycle_count)
   );

   riscv_test_sequencer #(.TIMEOUT(50)) dut_t (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .core_pc(core_pc), .core_gp(core_gp),
      .core_rst(t_core_rst), .busy(t_busy), .done(t_done), .pass(t_pass),
      .fail(t_fail), .timeout(t_timeout), .cycle_count(t_cycle_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic pulse_abort();
      @(negedge clk) abort = 1'b1;
      @(negedge clk) abort = 1'b0;
   endtask

   // Returns at the negedge before RUN edge 1
   task automatic wait_run();
      int i = 0;
      while (core_rst === 1'b1 && i < 20) begin
         @(negedge clk);
         i++;
      end
      chk("run_entry", {31'd0, core_rst}, 32'd0);
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
      chk("rst_flags", {26'd0, busy, done, pass, fail, timeout, 1'b0}, 32'd0);
      chk("rst_count", cycle_count, 32'd0);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_hold", {30'd0, core_rst, busy}, 32'b10);

      // 1: pass at RUN edge 101
      pulse_start();
      wait_run();
      repeat (100) @(negedge clk);
      chk("p_not_done", {31'd0, done}, 32'd0);
      core_pc = 32'h44; core_gp = 32'h1;
      @(negedge clk);
      core_pc = 32'h0;
      chk("p_flags", {27'd0, done, pass, fail, timeout, core_rst}, 32'b11001);
      chk("p_count", cycle_count, 32'd100);
      chk("p_busy", {31'd0, busy}, 32'd0);

      // 2: rerun from DONE clears results, then wrong gp
      pulse_start();
      chk("rr_clear", {28'd0, done, pass, fail, timeout}, 32'd0);
      chk("rr_count", cycle_count, 32'd0);
      wait_run();
      repeat (100) @(negedge clk);
      core_pc = 32'h44; core_gp = 32'h7;
      @(negedge clk);
      core_pc = 32'h0; core_gp = 32'h0;
      chk("f_flags", {28'd0, done, pass, fail, timeout}, 32'b1010);
      chk("f_count", cycle_count, 32'd100);
      pulse_abort();
      chk("done_abort_ign", {28'd0, done, pass, fail, timeout}, 32'b1010);

      // 6: abort in RUN, then restart core_rst timing
      pulse_start();
      wait_run();
      repeat (5) @(negedge clk);
      chk("ab_count", cycle_count, 32'd5);
      pulse_abort();
      chk("ab_idle", {29'd0, core_rst, busy, done}, 32'b100);
      chk("ab_count0", cycle_count, 32'd0);
      pulse_start();
      chk("rs_e0", {30'd0, core_rst, busy}, 32'b11);
      @(negedge clk);
      chk("rs_e1", {31'd0, core_rst}, 32'd1);
      @(negedge clk);
      chk("rs_e2", {31'd0, core_rst}, 32'd0);

      // 5: async reset at cycle_count=20
      repeat (20) @(negedge clk);
      chk("mr_count", cycle_count, 32'd20);
      #1 rst = 1'b0;
      #1;
      chk("mr_core_rst", {31'd0, core_rst}, 32'd1);
      chk("mr_flags", {27'd0, busy, done, pass, fail, timeout}, 32'd0);
      chk("mr_count0", cycle_count, 32'd0);
      @(negedge clk) rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("mr_idle", {30'd0, core_rst, busy}, 32'b10);

      // 3: timeout on 50th RUN edge
      pulse_start();
      wait_run();
      repeat (49) @(negedge clk);
      chk("to_pre_done", {31'd0, t_done}, 32'd0);
      chk("to_pre_count", t_cycle_count, 32'd49);
      @(negedge clk);
      chk("to_flags", {27'd0, t_done, t_pass, t_fail, t_timeout, t_core_rst}, 32'b10111);
      chk("to_count", t_cycle_count, 32'd49);

      // 4: PC match on the timeout edge wins
      pulse_abort();
      pulse_start();
      wait_run();
      repeat (49) @(negedge clk);
      core_pc = 32'h44; core_gp = 32'h1;
      @(negedge clk);
      core_pc = 32'h0;
      chk("tie_flags", {28'd0, t_done, t_pass, t_fail, t_timeout}, 32'b1100);
      chk("tie_count", t_cycle_count, 32'd49);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
